decode: RTL
===========

# decode

Instruction-decode pipeline stage of the MIPS core; the producer side of the execute stage's operand/control interface. It accepts a 32-bit instruction and splits it into fields. It reads rs/rt from an internal 32×32 register file that is written by the writeback port. It registers the opcode, funct, ALU-source select, raw immediate, operands and destination info into the ID/EX pipeline register. Its outputs connect one-to-one to the execute stage inputs (`ce`, `alu_src`, `imm`, `alu_op`, `alu_funct`, `data_rs`, `data_rt`).

## Interface
- `DWIDTH`, 32, register/operand width
- `AWIDTH`, 5, register address width (32 registers)
- `IMM_WIDTH`, 16, immediate width
- `ds_clk` in 1: clock, rising edge
- `ds_rst` in 1: reset, asynchronous, active-low
- `ds_i_ce` in 1: instruction valid this cycle
- `ds_i_instr` in 32: instruction word
- `ds_i_stall` in 1: hold ID/EX register
- `ds_i_flush` in 1: insert bubble
- `ds_i_wb_we` in 1: register-file write enable
- `ds_i_wb_addr` in AWIDTH: write address
- `ds_i_wb_data` in DWIDTH: write data
- `ds_o_ce` out 1: valid instruction presented to execute
- `ds_o_alu_op` out `OPCODE_WIDTH`: instr[31:26]
- `ds_o_alu_funct` out `FUNCT_WIDTH`: instr[5:0]
- `ds_o_alu_src` out 1: 1 selects immediate as operand 2
- `ds_o_imm` out IMM_WIDTH: instr[15:0], unextended (execute extends)
- `ds_o_data_rs` / `ds_o_data_rt` out DWIDTH: register operands
- `ds_o_rd_addr` out AWIDTH: destination register; rd for R-type, rt for I-type
- `ds_o_reg_write` out 1: instruction writes a register
- `ds_o_illegal` out 1: pulse, unsupported opcode/funct

## Operation
- Supported R-type instructions: opcode `RTYPE` = 000000 with funct ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110 or SLT 101010.
  - `alu_src`=0, `reg_write`=1.
- Supported I-type opcodes: ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, LW 100011.
  - `alu_src`=1, `reg_write`=1.
- SW 101011: `alu_src`=1, `reg_write`=0.
- BEQ 000100: `alu_src`=0, `reg_write`=0.
- Any other opcode, or RTYPE with any other funct, is illegal.
  - Registers `ds_o_illegal`=1, `ds_o_ce`=0, `ds_o_reg_write`=0.
  - Opcode/funct fields are still passed through.
- Register file:
  - r0 always reads 0; writes to r0 are ignored.
  - Writes take effect at the rising edge when `ds_i_wb_we`=1.
  - Writes proceed regardless of stall/flush/ce.
- ID/EX register update priority per edge: reset > flush > stall > load.
  - flush: all outputs are cleared to 0.
  - stall: all outputs hold their values, including operands (no refresh from a concurrent writeback).
  - load with `ds_i_ce`=1: decode result is captured.
  - load with `ds_i_ce`=0: all outputs are cleared to 0 (bubble).
- A non-registered instruction is never partially latched: every output updates on the same edge.

## Timing
- Reset (`ds_rst`=0), asynchronous: every output is 0 and all 32 registers are 0, immediately, without waiting for a clock edge.
- Latency is 1 cycle: an instruction present with `ds_i_ce`=1 at edge N appears on the outputs after edge N and is valid during cycle N+1.
- Throughput is 1 instruction per cycle when not stalled.
- `ds_o_illegal` is high for exactly one cycle per illegal instruction (longer only if stalled).
- Writeback and read of the same register in the same cycle: see Configuration.
- Reset deasserted mid-stream: the first instruction sampled is at the first rising edge with `ds_rst`=1.

## Configuration
- `DECODE_WB_BYPASS_EN` defined:
  - If `ds_i_wb_we`=1 and `ds_i_wb_addr` equals rs or rt (non-zero), the operand captured that edge is `ds_i_wb_data`.
  - This provides same-cycle write-then-read.
- Not defined: the captured operand is the old register value; the new value is visible from the following edge.

## Structure
- Shared header constants (alongside the execute stage definitions):
  - `OPCODE_WIDTH`, `FUNCT_WIDTH`, `RTYPE`
  - Funct codes `ADD`, `SUB`, `AND`, `OR`, `XOR`, `SLT`
  - I-type opcodes `ADDI`, `ANDI`, `ORI`, `XORI`, `LW`, `SW`, `BEQ`
- One sub-module, `register_file`:
  - Two combinational read ports, one synchronous write port, asynchronous active-low clear, r0 hardwired.
  - Contains the bypass logic under the macro.
- Decode logic and the ID/EX register live in `decode`.

## Test plan
- Reset held for 2 cycles, then released → all outputs 0; reads of r1..r31 return 0.
- Write r1=5 and r2=4 via wb, then ADD r3,r1,r2 with ce=1 → next cycle: ce=1, alu_op=000000, funct=100000, data_rs=5, data_rt=4, rd_addr=3, reg_write=1, alu_src=0.
- ADDI r4,r1,0x00FF → alu_src=1, imm=0x00FF, rd_addr=4, reg_write=1. SW → reg_write=0. BEQ → alu_src=0.
- Opcode 111111, or RTYPE with funct 000001 → illegal=1 for one cycle, ce=0, reg_write=0.
- Stall held 3 cycles during an ADD → outputs unchanged. Flush → all outputs 0 on the next edge. Write to r0 with 7, then read r0 → 0.
- Same-cycle wb r1=9 with ADD r3,r1,r2:
  - With `DECODE_WB_BYPASS_EN`: data_rs=9.
  - Without the macro: data_rs is the old value 5.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared MIPS decode/execute constants and the opcode/funct control lookup.
package decode_pkg;

  localparam int OPCODE_WIDTH = 6;
  localparam int FUNCT_WIDTH  = 6;

  localparam logic [OPCODE_WIDTH-1:0] RTYPE = 6'b000000;

  localparam logic [FUNCT_WIDTH-1:0] ADD = 6'b100000;
  localparam logic [FUNCT_WIDTH-1:0] SUB = 6'b100010;
  localparam logic [FUNCT_WIDTH-1:0] AND = 6'b100100;
  localparam logic [FUNCT_WIDTH-1:0] OR  = 6'b100101;
  localparam logic [FUNCT_WIDTH-1:0] XOR = 6'b100110;
  localparam logic [FUNCT_WIDTH-1:0] SLT = 6'b101010;

  localparam logic [OPCODE_WIDTH-1:0] ADDI = 6'b001000;
  localparam logic [OPCODE_WIDTH-1:0] ANDI = 6'b001100;
  localparam logic [OPCODE_WIDTH-1:0] ORI  = 6'b001101;
  localparam logic [OPCODE_WIDTH-1:0] XORI = 6'b001110;
  localparam logic [OPCODE_WIDTH-1:0] LW   = 6'b100011;
  localparam logic [OPCODE_WIDTH-1:0] SW   = 6'b101011;
  localparam logic [OPCODE_WIDTH-1:0] BEQ  = 6'b000100;

  typedef struct packed {
    logic legal;
    logic alu_src;
    logic reg_write;
    logic rd_is_rt;   // I-format: destination comes from the rt field
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [OPCODE_WIDTH-1:0] op,
                                        input logic [FUNCT_WIDTH-1:0]  funct);
    ctrl_t c;
    c = '0;
    case (op)
      RTYPE: if (funct inside {ADD, SUB, AND, OR, XOR, SLT})
               c = '{legal: 1'b1, alu_src: 1'b0, reg_write: 1'b1, rd_is_rt: 1'b0};
      ADDI, ANDI, ORI, XORI, LW:
             c = '{legal: 1'b1, alu_src: 1'b1, reg_write: 1'b1, rd_is_rt: 1'b1};
      SW:    c = '{legal: 1'b1, alu_src: 1'b1, reg_write: 1'b0, rd_is_rt: 1'b1};
      BEQ:   c = '{legal: 1'b1, alu_src: 1'b0, reg_write: 1'b0, rd_is_rt: 1'b1};
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_register_file.sv
// 32-entry register file: two combinational reads, one synchronous write, r0 hardwired.
// Optional write-to-read bypass when DECODE_WB_BYPASS_EN is defined.
module register_file #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic [AWIDTH-1:0] rd_addr_a,
  input  logic [AWIDTH-1:0] rd_addr_b,
  output logic [DWIDTH-1:0] rd_data_a,
  output logic [DWIDTH-1:0] rd_data_b
);

  localparam int NREGS = 1 << AWIDTH;

  logic [DWIDTH-1:0] regs [NREGS];

  // NOTE: the array is cleared by the async reset, so it maps to flops, not a RAM macro.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // NOTE: outputs get a default first so no path through always_comb infers a latch.
  always_comb begin
    rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
`ifdef DECODE_WB_BYPASS_EN
    if (we && rd_addr_a != '0 && rd_addr_a == wr_addr) rd_data_a = wr_data;
    if (we && rd_addr_b != '0 && rd_addr_b == wr_addr) rd_data_b = wr_data;
`endif
  end

endmodule

// File: rtl/decode.sv
// MIPS instruction-decode stage: field split, register read, ID/EX pipeline register.
// Define DECODE_WB_BYPASS_EN to forward same-cycle writeback data into the operands.
module decode
  import decode_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 5,
  parameter int IMM_WIDTH = 16
) (
  input  logic                    ds_clk,
  input  logic                    ds_rst,
  input  logic                    ds_i_ce,
  input  logic [31:0]             ds_i_instr,
  input  logic                    ds_i_stall,
  input  logic                    ds_i_flush,
  input  logic                    ds_i_wb_we,
  input  logic [AWIDTH-1:0]       ds_i_wb_addr,
  input  logic [DWIDTH-1:0]       ds_i_wb_data,
  output logic                    ds_o_ce,
  output logic [OPCODE_WIDTH-1:0] ds_o_alu_op,
  output logic [FUNCT_WIDTH-1:0]  ds_o_alu_funct,
  output logic                    ds_o_alu_src,
  output logic [IMM_WIDTH-1:0]    ds_o_imm,
  output logic [DWIDTH-1:0]       ds_o_data_rs,
  output logic [DWIDTH-1:0]       ds_o_data_rt,
  output logic [AWIDTH-1:0]       ds_o_rd_addr,
  output logic                    ds_o_reg_write,
  output logic                    ds_o_illegal
);

  typedef struct packed {
    logic                    ce;
    logic [OPCODE_WIDTH-1:0] op;
    logic [FUNCT_WIDTH-1:0]  funct;
    logic                    alu_src;
    logic [IMM_WIDTH-1:0]    imm;
    logic [DWIDTH-1:0]       data_rs;
    logic [DWIDTH-1:0]       data_rt;
    logic [AWIDTH-1:0]       rd_addr;
    logic                    reg_write;
    logic                    illegal;
  } idex_t;

  logic [OPCODE_WIDTH-1:0] op;
  logic [FUNCT_WIDTH-1:0]  funct;
  logic [AWIDTH-1:0]       rs_addr, rt_addr, rd_addr;
  logic [DWIDTH-1:0]       rs_data, rt_data;
  ctrl_t                   ctrl;
  idex_t                   idex_d, idex_q;

  assign op      = ds_i_instr[31:26];
  assign rs_addr = ds_i_instr[25:21];
  assign rt_addr = ds_i_instr[20:16];
  assign rd_addr = ds_i_instr[15:11];
  assign funct   = ds_i_instr[5:0];
  assign ctrl    = decode_ctrl(op, funct);

  register_file #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_regfile (
    .clk       (ds_clk),
    .rst_n     (ds_rst),
    .we        (ds_i_wb_we),
    .wr_addr   (ds_i_wb_addr),
    .wr_data   (ds_i_wb_data),
    .rd_addr_a (rs_addr),
    .rd_addr_b (rt_addr),
    .rd_data_a (rs_data),
    .rd_data_b (rt_data)
  );

  // Illegal instructions keep opcode/funct/operands visible but never validate or write.
  always_comb begin
    idex_d = '0;
    if (!ds_i_flush && ds_i_ce) begin
      idex_d.ce        = ctrl.legal;
      idex_d.op        = op;
      idex_d.funct     = funct;
      idex_d.alu_src   = ctrl.legal & ctrl.alu_src;
      idex_d.imm       = ds_i_instr[IMM_WIDTH-1:0];
      idex_d.data_rs   = rs_data;
      idex_d.data_rt   = rt_data;
      idex_d.rd_addr   = ctrl.legal ? (ctrl.rd_is_rt ? rt_addr : rd_addr) : '0;
      idex_d.reg_write = ctrl.legal & ctrl.reg_write;
      idex_d.illegal   = ~ctrl.legal;
    end
  end

  // Flush outranks stall; otherwise a stall holds the whole register, operands included.
  always_ff @(posedge ds_clk or negedge ds_rst) begin
    if (!ds_rst) begin
      idex_q <= '0;
    end else if (ds_i_flush || !ds_i_stall) begin
      idex_q <= idex_d;
    end
  end

  assign ds_o_ce        = idex_q.ce;
  assign ds_o_alu_op    = idex_q.op;
  assign ds_o_alu_funct = idex_q.funct;
  assign ds_o_alu_src   = idex_q.alu_src;
  assign ds_o_imm       = idex_q.imm;
  assign ds_o_data_rs   = idex_q.data_rs;
  assign ds_o_data_rt   = idex_q.data_rt;
  assign ds_o_rd_addr   = idex_q.rd_addr;
  assign ds_o_reg_write = idex_q.reg_write;
  assign ds_o_illegal   = idex_q.illegal;

endmodule
